// File: rtl/freq_calc.sv
// Frequency calculator: freq_out = REF_HZ * fx_cnt / base_cnt using a 64-iteration restoring divider.
// Optional FREQ_CALC_ROUND_EN: round to nearest Hz (halves up) instead of truncating.
module freq_calc #(
    parameter logic [31:0] REF_HZ = 32'd50_000_000,
    parameter int          CNT_W  = 32
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             cnt_valid,
    input  logic [CNT_W-1:0] fx_cnt,
    input  logic [CNT_W-1:0] base_cnt,
    output logic             busy,
    output logic             freq_valid,
    input  logic             freq_ack,
    output logic [31:0]      freq_out,
    output logic             div_err,
    output logic             sat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_rst_meta;
    logic               r_rst_sync;
    logic               w_rst_n;
    logic [CNT_W-1:0]   r_fx;
    logic [CNT_W-1:0]   r_base;
    logic [63:0]        r_dividend;
    logic [32:0]        r_rem;
    logic [63:0]        r_quot;
    logic [6:0]         r_iter;
    logic               r_busy;
    logic               r_valid;
    logic [31:0]        r_out;
    logic               r_div_err;
    logic               r_sat;

    logic [63:0]        w_product;
    logic [63:0]        w_dividend;
    logic [33:0]        w_rem_sh;
    logic               w_ge;
    logic [32:0]        w_diff;
    logic               w_sat;

    // NOTE: reset asserts asynchronously but releases on a clock edge, so no flop sees a
    // reset deassertion racing sysclk.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n   = r_rst_sync;
    assign w_product = 64'(REF_HZ) * 64'(r_fx);

`ifdef FREQ_CALC_ROUND_EN
    logic w_carry;
    logic r_carry;

    // Adding half the divisor before truncating gives round-half-up.
    assign {w_carry, w_dividend} = {1'b0, w_product} + {33'b0, r_base >> 1};
    assign w_sat = (|r_quot[63:32]) | r_carry;

    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_carry <= 1'b0;
        end else if (r_state == S_MUL) begin
            r_carry <= w_carry;
        end
    end
`else
    assign w_dividend = w_product;
    assign w_sat      = |r_quot[63:32];
`endif

    // Remainder stays below the divisor, so the shifted value and difference fit 33 bits.
    assign w_rem_sh = {r_rem, r_dividend[63]};
    assign w_ge     = (w_rem_sh >= {2'b00, r_base});
    assign w_diff   = w_rem_sh[32:0] - {1'b0, r_base};

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_fx       <= '0;
            r_base     <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_div_err  <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cnt_valid) begin
                        r_fx    <= fx_cnt;
                        r_base  <= base_cnt;
                        r_busy  <= 1'b1;
                        r_state <= (base_cnt == '0) ? S_DONE : S_MUL;
                    end
                end
                S_MUL: begin
                    r_dividend <= w_dividend;
                    r_rem      <= '0;
                    r_quot     <= '0;
                    r_iter     <= '0;
                    r_state    <= S_DIV;
                end
                S_DIV: begin
                    r_rem      <= w_ge ? w_diff : w_rem_sh[32:0];
                    r_quot     <= {r_quot[62:0], w_ge};
                    r_dividend <= {r_dividend[62:0], 1'b0};
                    r_iter     <= r_iter + 7'd1;
                    if (r_iter == 7'd63) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; ack is only honoured afterwards.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        if (r_base == '0) begin
                            r_out     <= '1;
                            r_div_err <= 1'b1;
                        end else if (w_sat) begin
                            r_out <= '1;
                            r_sat <= 1'b1;
                        end else begin
                            r_out <= r_quot[31:0];
                        end
                    end else if (freq_ack) begin
                        r_valid   <= 1'b0;
                        r_div_err <= 1'b0;
                        r_sat     <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign freq_valid = r_valid;
    assign freq_out   = r_out;
    assign div_err    = r_div_err;
    assign sat        = r_sat;

endmodule

// File: tb/tb_freq_calc.sv
// Self-checking bench for freq_calc: table of directed vectors plus hand-written corner sequences.
module tb_freq_calc;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        cnt_valid;
    logic [31:0] fx_cnt;
    logic [31:0] base_cnt;
    logic        busy;
    logic        freq_valid;
    logic        freq_ack;
    logic [31:0] freq_out;
    logic        div_err;
    logic        sat;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [31:0] fx;
        logic [31:0] base;
        logic [31:0] out;
        logic        err;
        logic        sat;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    freq_calc #(.REF_HZ(32'd50_000_000), .CNT_W(32)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .cnt_valid  (cnt_valid),
        .fx_cnt     (fx_cnt),
        .base_cnt   (base_cnt),
        .busy       (busy),
        .freq_valid (freq_valid),
        .freq_ack   (freq_ack),
        .freq_out   (freq_out),
        .div_err    (div_err),
        .sat        (sat)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cnt_valid pulse; returns half a cycle after the capture edge.
    task automatic apply(input logic [31:0] fx, input logic [31:0] base);
        @(negedge sysclk);
        cnt_valid = 1'b1;
        fx_cnt    = fx;
        base_cnt  = base;
        @(negedge sysclk);
        cnt_valid = 1'b0;
    endtask

    // Count rising edges until freq_valid is seen; 0 means the bound expired.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge sysclk);
            #1;
            if (freq_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge sysclk);
        freq_ack = 1'b1;
        @(negedge sysclk);
        freq_ack = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(freq_valid), 32'd0);
        check({tag, "_out"},   freq_out, 32'd0);
        check({tag, "_err"},   32'(div_err), 32'd0);
        check({tag, "_sat"},   32'(sat), 32'd0);
    endtask

    initial begin
        int    lat;
        bit    extra;
        string tag;

        vecs[0] = '{32'd1000,      32'd50_000_000, 32'd1000,          1'b0, 1'b0, 66};
`ifdef FREQ_CALC_ROUND_EN
        vecs[1] = '{32'd1,         32'd3,          32'd16_666_667,    1'b0, 1'b0, 66};
        vecs[2] = '{32'd1,         32'd256,        32'd195_313,       1'b0, 1'b0, 66};
`else
        vecs[1] = '{32'd1,         32'd3,          32'd16_666_666,    1'b0, 1'b0, 66};
        vecs[2] = '{32'd1,         32'd256,        32'd195_312,       1'b0, 1'b0, 66};
`endif
        vecs[3] = '{32'd5,         32'd0,          32'hFFFF_FFFF,     1'b1, 1'b0, 1};
        vecs[4] = '{32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,     1'b0, 1'b1, 66};
        vecs[5] = '{32'd0,         32'd12345,      32'd0,             1'b0, 1'b0, 66};
        vecs[6] = '{32'd12345,     32'd1_000_000,  32'd617_250,       1'b0, 1'b0, 66};
        vecs[7] = '{32'd3,         32'd7,          32'd21_428_571,    1'b0, 1'b0, 66};
        vecs[8] = '{32'd85,        32'd1,          32'd4_250_000_000, 1'b0, 1'b0, 66};
        vecs[9] = '{32'd86,        32'd1,          32'hFFFF_FFFF,     1'b0, 1'b1, 66};

        reset     = 1'b0;
        cnt_valid = 1'b0;
        freq_ack  = 1'b0;
        fx_cnt    = '0;
        base_cnt  = '0;
        repeat (3) @(negedge sysclk);
        check_zero("reset");
        reset = 1'b1;
        repeat (3) @(negedge sysclk);

        foreach (vecs[k]) begin
            tag = $sformatf("v%0d", k);
            apply(vecs[k].fx, vecs[k].base);
            check({tag, "_busy_cap"}, 32'(busy), 32'd1);
            wait_valid(lat);
            check({tag, "_lat"}, 32'(lat), 32'(vecs[k].lat));
            @(negedge sysclk);
            check({tag, "_out"},  freq_out, vecs[k].out);
            check({tag, "_err"},  32'(div_err), 32'(vecs[k].err));
            check({tag, "_sat"},  32'(sat), 32'(vecs[k].sat));
            check({tag, "_busy"}, 32'(busy), 32'd0);
            do_ack();
            check({tag, "_valid_ack"}, 32'(freq_valid), 32'd0);
            check({tag, "_err_ack"},   32'(div_err), 32'd0);
            check({tag, "_sat_ack"},   32'(sat), 32'd0);
            check({tag, "_out_keep"},  freq_out, vecs[k].out);
        end

        // Ack held through the edge where freq_valid rises is not honoured there.
        @(negedge sysclk);
        freq_ack = 1'b1;
        apply(32'd5, 32'd0);
        @(negedge sysclk);
        check("ack_early_valid", 32'(freq_valid), 32'd1);
        @(negedge sysclk);
        check("ack_early_clear", 32'(freq_valid), 32'd0);
        freq_ack = 1'b0;

        // cnt_valid coinciding with an accepted ack is dropped.
        apply(32'd5, 32'd0);
        @(negedge sysclk);
        check("ackcap_valid", 32'(freq_valid), 32'd1);
        freq_ack  = 1'b1;
        cnt_valid = 1'b1;
        fx_cnt    = 32'd9;
        base_cnt  = 32'd0;
        @(negedge sysclk);
        freq_ack  = 1'b0;
        cnt_valid = 1'b0;
        check("ackcap_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge sysclk);
        check("ackcap_novalid", 32'(freq_valid), 32'd0);

        // Second pulse during computation is dropped; result held while ack is low.
        apply(32'd1000, 32'd50_000_000);
        repeat (9) @(negedge sysclk);
        cnt_valid = 1'b1;
        fx_cnt    = 32'd5;
        base_cnt  = 32'd0;
        @(negedge sysclk);
        cnt_valid = 1'b0;
        wait_valid(lat);
        check("drop_lat", 32'(lat == 0 ? 0 : lat + 10), 32'd66);
        for (int c = 0; c < 20; c++) begin
            @(negedge sysclk);
            check("hold_state", {freq_out[28:0], freq_valid, div_err, sat},
                  {29'd1000, 1'b1, 1'b0, 1'b0});
        end
        do_ack();
        extra = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge sysclk);
            if (freq_valid || busy) extra = 1'b1;
        end
        check("drop_one_result", 32'(extra), 32'd0);

        // Reset in the middle of DIV aborts; a fresh pair then computes normally.
        apply(32'd1000, 32'd50_000_000);
        repeat (31) @(negedge sysclk);
        reset = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        check_zero("postreset");
        apply(32'd7, 32'd50_000_000);
        wait_valid(lat);
        check("rst_lat", 32'(lat), 32'd66);
        @(negedge sysclk);
        check("rst_out", freq_out, 32'd7);
        do_ack();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
